// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if
//   Bundles the instruction fields and the control word exchanged between the
//   multi-cycle controller and its datapath.
//   Ports (as seen by the controller through modport master):
//     op[6:0]        Instr[6:0] from the instruction register
//     funct3[2:0]    Instr[14:12]
//     funct7b5       Instr[30]
//     Zero           ALU zero flag
//     PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite     enables / 1-bit selects
//     ResultSrc[1:0], ALUSrcA[1:0], ALUSrcB[1:0]       mux selects
//     ALUControl[2:0], ImmSrc[1:0]                     ALU op, immediate format
//     State[3:0]     current state code (debug)
//     Illegal        high while halted on an unsupported opcode
//   Modport slave is the datapath side.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] ImmSrc;
  logic [3:0] State;
  logic       Illegal;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, State, Illegal
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, State, Illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Moore control FSM for the multi-cycle RV32I datapath (shared memory,
//   IR/OldPC, ALUOut/Data/A/B holding registers). Supports lw, sw, R-type,
//   I-type ALU, beq, bne and jal, one state per clock.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-high reset, forces FETCH
//     ctrl   multicycle_controller_if.master (instruction fields in,
//            control word out)
//   Configuration macro: ILLEGAL_HALT_EN
//     defined   -> unsupported opcode halts in HALT with Illegal=1 until reset
//     undefined -> unsupported opcode is a 2-cycle NOP, Illegal tied 0
module multicycle_controller (
  input  logic                          clk,
  input  logic                          reset,
  multicycle_controller_if.master       ctrl
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    HALT     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t state;
  logic [2:0] alu_decoded;

  // State register and next-state logic. The IR holds op stable for the whole
  // instruction, so MEMADR can still tell lw from sw by looking at op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:    state <= DECODE;
        DECODE: begin
          case (ctrl.op)
            OP_LW, OP_SW: state <= MEMADR;
            OP_R:         state <= EXECUTER;
            OP_I:         state <= EXECUTEI;
            OP_BR:        state <= BRANCH;
            OP_JAL:       state <= JAL;
`ifdef ILLEGAL_HALT_EN
            default:      state <= HALT;
`else
            default:      state <= FETCH;
`endif
          endcase
        end
        MEMADR:   state <= (ctrl.op == OP_SW) ? MEMWRITE : MEMREAD;
        MEMREAD:  state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: state <= FETCH;
        EXECUTER: state <= ALUWB;
        EXECUTEI: state <= ALUWB;
        ALUWB:    state <= FETCH;
        BRANCH:   state <= FETCH;
        JAL:      state <= ALUWB;
`ifdef ILLEGAL_HALT_EN
        HALT:     state <= HALT;
`endif
        default:  state <= FETCH;
      endcase
    end
  end

  // ALU operation for the two execute states. Only R-type with Instr[30] set
  // subtracts; addi ignores Instr[30] because it is part of the immediate.
  always_comb begin
    alu_decoded = ALU_ADD;
    case (ctrl.funct3)
      3'b000:  alu_decoded = ((ctrl.op == OP_R) && ctrl.funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_decoded = ALU_SLT;
      3'b110:  alu_decoded = ALU_OR;
      3'b111:  alu_decoded = ALU_AND;
      default: alu_decoded = ALU_ADD;
    endcase
  end

  // Control word per state. Everything defaults to 00/0 so each state only
  // lists what it drives. Zero only matters in BRANCH.
  always_comb begin
    ctrl.PCWrite    = 1'b0;
    ctrl.AdrSrc     = 1'b0;
    ctrl.MemWrite   = 1'b0;
    ctrl.IRWrite    = 1'b0;
    ctrl.RegWrite   = 1'b0;
    ctrl.ResultSrc  = 2'b00;
    ctrl.ALUSrcA    = 2'b00;
    ctrl.ALUSrcB    = 2'b00;
    ctrl.ALUControl = ALU_ADD;
    case (state)
      FETCH: begin
        ctrl.IRWrite   = 1'b1;
        ctrl.ALUSrcB   = 2'b10;
        ctrl.ResultSrc = 2'b10;
        ctrl.PCWrite   = 1'b1;
      end
      DECODE: begin
        ctrl.ALUSrcA = 2'b01;
        ctrl.ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ctrl.ALUSrcA = 2'b10;
        ctrl.ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        ctrl.AdrSrc = 1'b1;
      end
      MEMWB: begin
        ctrl.ResultSrc = 2'b01;
        ctrl.RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        ctrl.AdrSrc   = 1'b1;
        ctrl.MemWrite = 1'b1;
      end
      EXECUTER: begin
        ctrl.ALUSrcA    = 2'b10;
        ctrl.ALUControl = alu_decoded;
      end
      EXECUTEI: begin
        ctrl.ALUSrcA    = 2'b10;
        ctrl.ALUSrcB    = 2'b01;
        ctrl.ALUControl = alu_decoded;
      end
      ALUWB: begin
        ctrl.RegWrite = 1'b1;
      end
      BRANCH: begin
        ctrl.ALUSrcA    = 2'b10;
        ctrl.ALUControl = ALU_SUB;
        if (ctrl.funct3 == 3'b000)
          ctrl.PCWrite = ctrl.Zero;
        else if (ctrl.funct3 == 3'b001)
          ctrl.PCWrite = ~ctrl.Zero;
      end
      JAL: begin
        ctrl.ALUSrcA = 2'b01;
        ctrl.ALUSrcB = 2'b10;
        ctrl.PCWrite = 1'b1;
      end
      default: begin
        ctrl.PCWrite = 1'b0;
      end
    endcase
  end

  // Immediate format depends only on the opcode, valid in every state.
  always_comb begin
    case (ctrl.op)
      OP_SW:   ctrl.ImmSrc = 2'b01;
      OP_BR:   ctrl.ImmSrc = 2'b10;
      OP_JAL:  ctrl.ImmSrc = 2'b11;
      default: ctrl.ImmSrc = 2'b00;
    endcase
  end

  assign ctrl.State = state;

`ifdef ILLEGAL_HALT_EN
  assign ctrl.Illegal = (state == HALT);
`else
  assign ctrl.Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
//   Drives instruction fields into multicycle_controller and compares the full
//   control word every cycle against a per-instruction timeline model.
//   Honours ILLEGAL_HALT_EN the same way the design does.
module tb_multicycle_controller;

  typedef enum int {K_LW, K_SW, K_R, K_I, K_BR, K_JAL, K_BAD} kind_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic kind_t classify(input logic [6:0] op);
    case (op)
      7'b0000011: return K_LW;
      7'b0100011: return K_SW;
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b1100011: return K_BR;
      7'b1101111: return K_JAL;
      default:    return K_BAD;
    endcase
  endfunction

  // Total cycles the instruction occupies, FETCH included.
  function automatic int cyclesOf(input kind_t k);
    case (k)
      K_LW:    return 5;
      K_SW:    return 4;
      K_R:     return 4;
      K_I:     return 4;
      K_BR:    return 3;
      K_JAL:   return 4;
      default: return 2;
    endcase
  endfunction

  function automatic logic [1:0] immOf(input kind_t k);
    case (k)
      K_SW:    return 2'b01;
      K_BR:    return 2'b10;
      K_JAL:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] aluOf(input kind_t k, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (k == K_R && f7) ? 3'b001 : 3'b000;
      3'd2:    return 3'b101;
      3'd6:    return 3'b011;
      3'd7:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Word layout: PCWrite AdrSrc MemWrite IRWrite RegWrite ResultSrc ALUSrcA
  // ALUSrcB ALUControl ImmSrc State Illegal (21 bits).
  function automatic logic [31:0] pack(input logic pcw, input logic adr, input logic mw,
                                       input logic ir, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] alu, input logic [1:0] imm,
                                       input logic [3:0] st, input logic ill);
    return {11'd0, pcw, adr, mw, ir, rw, rs, sa, sb, alu, imm, st, ill};
  endfunction

  function automatic logic [31:0] observed();
    return pack(bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc,
                bus.State, bus.Illegal);
  endfunction

  // Expected control word for cycle idx of an instruction of kind k.
  function automatic logic [31:0] modelWord(input kind_t k, input logic [2:0] f3,
                                            input logic f7, input logic z, input int idx);
    logic [1:0] imm;
    logic       take;
    imm = immOf(k);
    if (idx == 0) return pack(1, 0, 0, 1, 0, 2'd2, 2'd0, 2'd2, 3'd0, imm, 4'd0, 0);
    if (idx == 1) return pack(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd0, imm, 4'd1, 0);
    if (k == K_LW || k == K_SW) begin
      if (idx == 2) return pack(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, imm, 4'd2, 0);
      if (k == K_SW) return pack(0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, imm, 4'd5, 0);
      if (idx == 3) return pack(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, imm, 4'd3, 0);
      return pack(0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 3'd0, imm, 4'd4, 0);
    end
    if (k == K_BR) begin
      take = (f3 == 3'd0) ? z : ((f3 == 3'd1) ? !z : 1'b0);
      return pack(take, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd1, imm, 4'd9, 0);
    end
    // R, I and JAL all finish with a register write in ALUWB
    if (idx == 3) return pack(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, imm, 4'd8, 0);
    if (k == K_R)  return pack(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, aluOf(k, f3, f7), imm, 4'd6, 0);
    if (k == K_I)  return pack(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, aluOf(k, f3, f7), imm, 4'd7, 0);
    return pack(1, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 3'd0, imm, 4'd10, 0);
  endfunction

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Assert reset between edges, check the FETCH word appears at once, hold
  // through one edge and release just after it so FETCH is the current state.
  task automatic applyReset(input string tag);
    reset = 1'b1;
    #1;
    checkOutput({tag, " rst"}, observed(), modelWord(classify(bus.op), 3'd0, 1'b0, 1'b0, 0));
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Run one instruction starting in FETCH at posedge+1. zsel<0 randomises
  // Zero every cycle; abortAt>=0 resets mid-instruction after that cycle.
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                               input int zsel, input int abortAt);
    kind_t k;
    int    n;
    k = classify(op);
    n = cyclesOf(k);
    bus.op       = op;
    bus.funct3   = f3;
    bus.funct7b5 = f7;
    for (int idx = 0; idx < n; idx++) begin
      bus.Zero = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
      #2;
      checkOutput($sformatf("op%02h f3=%0d c%0d", op, f3, idx), observed(),
                  modelWord(k, f3, f7, bus.Zero, idx));
      if (idx == abortAt) begin
        #1;
        applyReset($sformatf("abort op%02h c%0d", op, idx));
        return;
      end
      @(posedge clk);
      #1;
    end
`ifdef ILLEGAL_HALT_EN
    if (k == K_BAD) begin
      for (int h = 0; h < 20; h++) begin
        bus.Zero = 1'($urandom_range(0, 1));
        #2;
        checkOutput($sformatf("halt op%02h h%0d", op, h), observed(),
                    pack(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 4'd11, 1));
        @(posedge clk);
        #1;
      end
      applyReset("halt exit");
    end
`endif
  endtask

  initial begin
    logic [6:0] rop;
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.op       = 7'b0000011;
    bus.funct3   = 3'd0;
    bus.funct7b5 = 1'b0;
    bus.Zero     = 1'b0;
    #2;
    checkOutput("reset word", observed(), modelWord(K_LW, 3'd0, 1'b0, 1'b0, 0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed instructions
    applyStimulus(7'b0000011, 3'd2, 1'b0, -1, -1);   // lw
    applyStimulus(7'b0100011, 3'd2, 1'b0, -1, -1);   // sw
    applyStimulus(7'b0110011, 3'd0, 1'b1, -1, -1);   // sub
    applyStimulus(7'b0110011, 3'd0, 1'b0, -1, -1);   // add
    applyStimulus(7'b0010011, 3'd0, 1'b1, -1, -1);   // addi, Instr[30]=1
    applyStimulus(7'b0110011, 3'd2, 1'b0, -1, -1);   // slt
    applyStimulus(7'b0010011, 3'd6, 1'b0, -1, -1);   // ori
    applyStimulus(7'b0010011, 3'd7, 1'b0, -1, -1);   // andi
    applyStimulus(7'b1100011, 3'd0, 1'b0, 1, -1);    // beq taken
    applyStimulus(7'b1100011, 3'd0, 1'b0, 0, -1);    // beq not taken
    applyStimulus(7'b1100011, 3'd1, 1'b0, 1, -1);    // bne not taken
    applyStimulus(7'b1100011, 3'd1, 1'b0, 0, -1);    // bne taken
    applyStimulus(7'b1101111, 3'd0, 1'b0, -1, -1);   // jal
    applyStimulus(7'b0000000, 3'd0, 1'b0, -1, -1);   // unsupported
    applyStimulus(7'b0000011, 3'd2, 1'b0, -1, 3);    // lw aborted in MEMREAD
    applyStimulus(7'b0000011, 3'd2, 1'b0, -1, -1);   // lw after abort

    // Randomised instruction stream
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 7))
        0: rop = 7'b0000011;
        1: rop = 7'b0100011;
        2: rop = 7'b0110011;
        3: rop = 7'b0010011;
        4: rop = 7'b1100011;
        5: rop = 7'b1101111;
        6: rop = 7'b0110011;
        default: begin
          rop = 7'($urandom);
          if (classify(rop) != K_BAD) rop = 7'h7f;
        end
      endcase
      applyStimulus(rop, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style control FSM that sequences the team's multi-cycle RV32I datapath variant: one shared instruction/data memory, instruction register, and ALUOut/Data/A/B holding registers. Inputs: opcode/funct fields from the instruction register and the ALU Zero flag. Outputs: every mux select and write enable, one state per clock. Supports lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq, bne and jal.

## Interface
- No parameters; all widths fixed.
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; forces state to FETCH
- op  input  7  Instr[6:0] from instruction register
- funct3  input  3  Instr[14:12]
- funct7b5  input  1  Instr[30]
- Zero  input  1  ALU zero flag
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address: 0=PC, 1=Result
- MemWrite  output  1  memory write enable
- IRWrite  output  1  IR/OldPC load enable
- RegWrite  output  1  register file write enable
- ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  output  2  00=PC, 01=OldPC, 10=A
- ALUSrcB  output  2  00=B, 01=ImmExt, 10=constant 4
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  output  2  00 I, 01 S, 10 B, 11 J
- State  output  4  current state code (debug)
- Illegal  output  1  high while in HALT

## Operation
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9, JAL 10, HALT 11; codes 12-15 → FETCH.
- Unlisted selects are 00/0; unlisted enables are 0.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCWrite=1 → DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target into ALUOut). Next state by op:
  - 0000011 → MEMADR
  - 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - other → illegal handling (Configuration)
- MEMADR: ALUSrcA=10, ALUSrcB=01, add → MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: ResultSrc=00, AdrSrc=1 → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 → FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALU decode → ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALU decode → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite=Zero for funct3 000; PCWrite=~Zero for 001; 0 otherwise.
  - → FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 → ALUWB (rd ← OldPC+4).
- ALU decode (EXECUTER/EXECUTEI only), by funct3:
  - 000: sub iff R-type and funct7b5=1, else add
  - 010: slt
  - 110: or
  - 111: and
  - other: add
- ImmSrc: combinational from op in every state. sw→01, branch→10, jal→11, else 00.

## Timing
- State register updates on rising clk; all outputs are combinational from state, op, funct3, funct7b5 and Zero.
- Reset asserts State=0 immediately, no clock needed. Outputs then equal FETCH values: PCWrite=1, IRWrite=1, ALUSrcB=10, ResultSrc=10, all else 0, Illegal=0.
- Reset asserted mid-instruction aborts it; no further write enable beyond FETCH's.
- Cycles per instruction: lw 5, sw 4, R 4, I 4, beq/bne 3, jal 4.
- Zero is sampled only combinationally in BRANCH; changes elsewhere have no effect.

## Configuration
- ILLEGAL_HALT_EN defined:
  - Unsupported op in DECODE → HALT.
  - HALT asserts Illegal=1 and all enables 0.
  - HALT holds until reset.
- ILLEGAL_HALT_EN undefined:
  - Unsupported op → FETCH (treated as NOP, 2 cycles).
  - State 11 unreachable; Illegal tied 0.

## Test plan
- Reset asserted in MEMREAD between edges → State=0 at once, PCWrite=1 and IRWrite=1 combinationally; next edge → State=1.
- lw (op 0000011) from reset → State 0,1,2,3,4,0 over 5 edges; RegWrite=1 and ResultSrc=01 only in state 4.
- sub R-type (op 0110011, funct3 000, funct7b5 1) → ALUControl=001 in state 6; same with funct7b5 0 → 000; addi with Instr[30]=1 → 000.
- beq, funct3 000: Zero=1 → PCWrite=1 in state 9; Zero=0 → PCWrite=0. bne, funct3 001: inverse. Both return to state 0 after 3 cycles.
- jal → states 0,1,10,8,0; PCWrite=1 in 10; RegWrite=1 in 8; ImmSrc=11 throughout.
- op 0000000:
  - with ILLEGAL_HALT_EN → State=11, Illegal=1, held 20 cycles until reset.
  - without → State returns to 0 after DECODE, Illegal=0.
